// File: rtl/sram_arbiter.sv
// Two-port arbiter onto one asynchronous SRAM: the recorder writes, the DSP reads, and each access takes two cycles.
// Define SRAM_ARB_RR_EN for round-robin arbitration. The default build uses write priority.
module sram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, RD_ACCESS, RD_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                we_n_q, we_n_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic                wr_ack_q, wr_ack_d;
    logic                rd_ack_q, rd_ack_d;
    logic                busy_q, busy_d;
    logic                grant_wr, grant_rd;
`ifdef SRAM_ARB_RR_EN
    logic                last_wr_q, last_wr_d;
`endif

`ifdef SRAM_ARB_RR_EN
    // When both ports request, the port that was not granted last wins.
    assign grant_wr = i_wr_req && (!i_rd_req || !last_wr_q);
`else
    assign grant_wr = i_wr_req;
`endif
    assign grant_rd = i_rd_req && !grant_wr;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
`ifdef SRAM_ARB_RR_EN
        last_wr_d = last_wr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d   = WR_SETUP;
                    addr_d    = i_wr_addr;
                    wr_data_d = i_wr_data;
`ifdef SRAM_ARB_RR_EN
                    last_wr_d = 1'b1;
`endif
                end else if (grant_rd) begin
                    state_d   = RD_ACCESS;
                    addr_d    = i_rd_addr;
`ifdef SRAM_ARB_RR_EN
                    last_wr_d = 1'b0;
`endif
                end
            end
            WR_SETUP:  state_d = WR_PULSE;
            WR_PULSE:  state_d = IDLE;
            RD_ACCESS: begin
                rd_data_d = io_SRAM_DQ;
                state_d   = RD_DONE;
            end
            RD_DONE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // The pin controls are computed from the next state, so they change on the same edge as the state.
        ce_n_d   = (state_d == IDLE);
        we_n_d   = (state_d != WR_PULSE);
        oe_n_d   = !(state_d inside {RD_ACCESS, RD_DONE});
        dq_oe_d  = (state_d inside {WR_SETUP, WR_PULSE});
        wr_ack_d = (state_d == WR_PULSE);
        rd_ack_d = (state_d == RD_DONE);
        busy_d   = (state_d != IDLE);
    end

    // NOTE: non-blocking assignments make every flop sample its pre-edge value, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            we_n_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_wr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            we_n_q    <= we_n_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            dq_oe_q   <= dq_oe_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            busy_q    <= busy_d;
`ifdef SRAM_ARB_RR_EN
            last_wr_q <= last_wr_d;
`endif
        end
    end

    // A reset during the ack cycle aborts the transaction, so the ack is masked in that cycle.
    assign o_wr_ack    = wr_ack_q && !i_rst;
    assign o_rd_ack    = rd_ack_q && !i_rst;
    assign o_rd_data   = rd_data_q;
    assign o_busy      = busy_q;
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_WE_N = we_n_q;
    assign o_SRAM_CE_N = ce_n_q;
    assign o_SRAM_OE_N = oe_n_q;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;
    assign io_SRAM_DQ  = dq_oe_q ? wr_data_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. It drives cycle tables and multi-cycle sequences against an SRAM model on a pulled-up DQ bus.
// Build it with SRAM_ARB_RR_EN defined to check the round-robin arbitration.
module tb_sram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_wr_req = 1'b0;
    logic [19:0] i_wr_addr = '0;
    logic [15:0] i_wr_data = '0;
    logic        i_rd_req = 1'b0;
    logic [19:0] i_rd_addr = '0;
    logic        o_wr_ack, o_rd_ack, o_busy;
    logic [15:0] o_rd_data;
    logic [19:0] sram_addr;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;
    wire  [15:0] dq;

    int n_tests = 0;
    int n_fail  = 0;

    sram_arbiter dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_req   (i_wr_req),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .o_wr_ack   (o_wr_ack),
        .i_rd_req   (i_rd_req),
        .i_rd_addr  (i_rd_addr),
        .o_rd_ack   (o_rd_ack),
        .o_rd_data  (o_rd_data),
        .o_busy     (o_busy),
        .o_SRAM_ADDR(sram_addr),
        .io_SRAM_DQ (dq),
        .o_SRAM_WE_N(we_n),
        .o_SRAM_CE_N(ce_n),
        .o_SRAM_OE_N(oe_n),
        .o_SRAM_LB_N(lb_n),
        .o_SRAM_UB_N(ub_n)
    );

    always #5 i_clk = ~i_clk;

    // When nothing drives DQ, the bus reads all ones.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup pu (dq[g]);
    end

    // SRAM model: it drives DQ while output-enabled and stores DQ on a clock edge while WE_N is low.
    logic [15:0] mem [256];
    logic        sram_drive;
    assign sram_drive = !ce_n && !oe_n && we_n;
    assign dq = sram_drive ? mem[sram_addr[7:0]] : 16'hzzzz;
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    always @(posedge i_clk) if (!ce_n && !we_n) mem[sram_addr[7:0]] <= dq;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        check(name, {31'd0, got}, {31'd0, exp});
    endtask

    // The task drives one cycle's inputs just after the rising edge, then waits so the outputs settle before the checks.
    task automatic step(input logic wr, input logic [19:0] wa, input logic [15:0] wd,
                        input logic rd, input logic [19:0] ra, input logic rst);
        @(posedge i_clk);
        #1;
        i_wr_req = wr; i_wr_addr = wa; i_wr_data = wd;
        i_rd_req = rd; i_rd_addr = ra; i_rst = rst;
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b1);
        step(1'b0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b1);
    endtask

    // ctl bit order is {busy, wr_ack, rd_ack, we_n, ce_n, oe_n}.
    typedef struct {
        logic        wr;
        logic [19:0] wa;
        logic [15:0] wd;
        logic        rd;
        logic [19:0] ra;
        logic [5:0]  ctl;
        logic [15:0] rdata;
        logic [19:0] addr;
        logic [15:0] dq;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic wr, input logic [19:0] wa, input logic [15:0] wd,
                       input logic rd, input logic [19:0] ra, input logic [5:0] ctl,
                       input logic [15:0] rdata, input logic [19:0] addr, input logic [15:0] dqv);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
        v.ctl = ctl; v.rdata = rdata; v.addr = addr; v.dq = dqv;
        tbl.push_back(v);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_ack_at;
        int wr_acks;
        int rd_acks;
        logic rd_pend;

        // Write 0x10=A5A5, read it back, do back-to-back writes to 0x20/0x21, then back-to-back reads of both.
        row(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 6'b000111, 16'h0000, 20'h00000, 16'hFFFF);
        row(1'b1, 20'h10, 16'hA5A5, 1'b0, 20'h00, 6'b000111, 16'h0000, 20'h00000, 16'hFFFF);
        row(1'b1, 20'h10, 16'hA5A5, 1'b0, 20'h00, 6'b100101, 16'h0000, 20'h00010, 16'hA5A5);
        row(1'b1, 20'h10, 16'hA5A5, 1'b0, 20'h00, 6'b110001, 16'h0000, 20'h00010, 16'hA5A5);
        row(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 6'b000111, 16'h0000, 20'h00010, 16'hFFFF);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h10, 6'b000111, 16'h0000, 20'h00010, 16'hFFFF);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h10, 6'b100100, 16'h0000, 20'h00010, 16'hA5A5);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h10, 6'b101100, 16'hA5A5, 20'h00010, 16'hA5A5);
        row(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 6'b000111, 16'hA5A5, 20'h00010, 16'hFFFF);
        row(1'b1, 20'h20, 16'h5A3C, 1'b0, 20'h00, 6'b000111, 16'hA5A5, 20'h00010, 16'hFFFF);
        row(1'b1, 20'h20, 16'h5A3C, 1'b0, 20'h00, 6'b100101, 16'hA5A5, 20'h00020, 16'h5A3C);
        row(1'b1, 20'h20, 16'h5A3C, 1'b0, 20'h00, 6'b110001, 16'hA5A5, 20'h00020, 16'h5A3C);
        row(1'b1, 20'h21, 16'h1234, 1'b0, 20'h00, 6'b000111, 16'hA5A5, 20'h00020, 16'hFFFF);
        row(1'b1, 20'h21, 16'h1234, 1'b0, 20'h00, 6'b100101, 16'hA5A5, 20'h00021, 16'h1234);
        row(1'b1, 20'h21, 16'h1234, 1'b0, 20'h00, 6'b110001, 16'hA5A5, 20'h00021, 16'h1234);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h20, 6'b000111, 16'hA5A5, 20'h00021, 16'hFFFF);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h20, 6'b100100, 16'hA5A5, 20'h00020, 16'h5A3C);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h20, 6'b101100, 16'h5A3C, 20'h00020, 16'h5A3C);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h21, 6'b000111, 16'h5A3C, 20'h00020, 16'hFFFF);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h21, 6'b100100, 16'h5A3C, 20'h00021, 16'h1234);
        row(1'b0, 20'h00, 16'h0000, 1'b1, 20'h21, 6'b101100, 16'h1234, 20'h00021, 16'h1234);
        row(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 6'b000111, 16'h1234, 20'h00021, 16'hFFFF);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra, 1'b0);
            check_bit($sformatf("row%0d busy", i),   o_busy,   tbl[i].ctl[5]);
            check_bit($sformatf("row%0d wr_ack", i), o_wr_ack, tbl[i].ctl[4]);
            check_bit($sformatf("row%0d rd_ack", i), o_rd_ack, tbl[i].ctl[3]);
            check_bit($sformatf("row%0d we_n", i),   we_n,     tbl[i].ctl[2]);
            check_bit($sformatf("row%0d ce_n", i),   ce_n,     tbl[i].ctl[1]);
            check_bit($sformatf("row%0d oe_n", i),   oe_n,     tbl[i].ctl[0]);
            check_bit($sformatf("row%0d lb_ub", i),  lb_n | ub_n, 1'b0);
            check($sformatf("row%0d rd_data", i), {16'd0, o_rd_data}, {16'd0, tbl[i].rdata});
            check($sformatf("row%0d addr", i),    {12'd0, sram_addr}, {12'd0, tbl[i].addr});
            check($sformatf("row%0d dq", i),      {16'd0, dq},        {16'd0, tbl[i].dq});
        end

        // Both ports request together after reset: the write is granted first and the read follows.
        do_reset();
        step(1'b1, 20'h30, 16'hC3C3, 1'b1, 20'h30, 1'b0);
        check_bit("sim t busy", o_busy, 1'b0);
        step(1'b1, 20'h30, 16'hC3C3, 1'b1, 20'h30, 1'b0);
        check_bit("sim t+1 oe_n", oe_n, 1'b1);
        check("sim t+1 dq", {16'd0, dq}, 32'h0000C3C3);
        step(1'b1, 20'h30, 16'hC3C3, 1'b1, 20'h30, 1'b0);
        check_bit("sim t+2 wr_ack", o_wr_ack, 1'b1);
        check_bit("sim t+2 rd_ack", o_rd_ack, 1'b0);
        step(1'b0, 20'h00, 16'h0000, 1'b1, 20'h30, 1'b0);
        check_bit("sim t+3 busy", o_busy, 1'b0);
        step(1'b0, 20'h00, 16'h0000, 1'b1, 20'h30, 1'b0);
        check_bit("sim t+4 oe_n", oe_n, 1'b0);
        step(1'b0, 20'h00, 16'h0000, 1'b1, 20'h30, 1'b0);
        check_bit("sim t+5 rd_ack", o_rd_ack, 1'b1);
        check("sim t+5 rd_data", {16'd0, o_rd_data}, 32'h0000C3C3);
        step(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 1'b0);

        // The write request is held for 12 cycles while a read stays pending.
        do_reset();
        rd_pend = 1'b1; rd_ack_at = -1; wr_acks = 0; rd_acks = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 20'h40, 16'h0F0F, rd_pend, 20'h30, 1'b0);
            if (o_wr_ack) wr_acks++;
            if (o_rd_ack) begin
                rd_acks++;
                if (rd_ack_at < 0) rd_ack_at = k;
                rd_pend = 1'b0;
            end
        end
        step(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 1'b0);
`ifdef SRAM_ARB_RR_EN
        check("rr rd_ack cycle", rd_ack_at, 5);
        check("rr rd_acks", rd_acks, 1);
        check("rr wr_acks", wr_acks, 3);
`else
        check("fixed rd_acks", rd_acks, 0);
        check("fixed wr_acks", wr_acks, 4);
`endif

        // Reset arrives in the WR_PULSE cycle: the write must not be acknowledged.
        do_reset();
        step(1'b1, 20'h50, 16'hBEEF, 1'b0, 20'h00, 1'b0);
        step(1'b1, 20'h50, 16'hBEEF, 1'b0, 20'h00, 1'b0);
        check_bit("rst setup we_n", we_n, 1'b1);
        step(1'b1, 20'h50, 16'hBEEF, 1'b0, 20'h00, 1'b1);
        check_bit("rst pulse wr_ack", o_wr_ack, 1'b0);
        step(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 1'b0);
        check_bit("rst after busy", o_busy, 1'b0);
        check_bit("rst after we_n", we_n, 1'b1);
        check_bit("rst after ce_n", ce_n, 1'b1);
        check_bit("rst after oe_n", oe_n, 1'b1);
        check_bit("rst after wr_ack", o_wr_ack, 1'b0);
        check("rst after dq", {16'd0, dq}, 32'h0000FFFF);
        check("rst after addr", {12'd0, sram_addr}, 32'h0);
        check("rst after rd_data", {16'd0, o_rd_data}, 32'h0);
        step(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 1'b0);
        check_bit("rst later wr_ack", o_wr_ack, 1'b0);

        // A read that arrives during WR_SETUP enters RD_ACCESS 3 cycles later and is acked 4 cycles later.
        step(1'b1, 20'h60, 16'h7777, 1'b0, 20'h00, 1'b0);
        step(1'b1, 20'h60, 16'h7777, 1'b1, 20'h10, 1'b0);
        check_bit("late rd setup we_n", we_n, 1'b1);
        check("late rd setup dq", {16'd0, dq}, 32'h00007777);
        step(1'b1, 20'h60, 16'h7777, 1'b1, 20'h10, 1'b0);
        check_bit("late rd +1 wr_ack", o_wr_ack, 1'b1);
        step(1'b0, 20'h00, 16'h0000, 1'b1, 20'h10, 1'b0);
        check_bit("late rd +2 busy", o_busy, 1'b0);
        step(1'b0, 20'h00, 16'h0000, 1'b1, 20'h10, 1'b0);
        check_bit("late rd +3 oe_n", oe_n, 1'b0);
        check_bit("late rd +3 rd_ack", o_rd_ack, 1'b0);
        step(1'b0, 20'h00, 16'h0000, 1'b1, 20'h10, 1'b0);
        check_bit("late rd +4 rd_ack", o_rd_ack, 1'b1);
        check("late rd +4 rd_data", {16'd0, o_rd_data}, 32'h0000A5A5);
        step(1'b0, 20'h00, 16'h0000, 1'b0, 20'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-004 SHALL have port i_rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port i_wr_req, input, 1, recorder write request; held until o_wr_ack.
REQ-006 SHALL have port i_wr_addr, input, ADDR_W, write address; stable while i_wr_req.
REQ-007 SHALL have port i_wr_data, input, DATA_W, write data; stable while i_wr_req.
REQ-008 SHALL have port o_wr_ack, output, 1, one-cycle write-complete pulse.
REQ-009 SHALL have port i_rd_req, input, 1, DSP read request; held until o_rd_ack.
REQ-010 SHALL have port i_rd_addr, input, ADDR_W, read address; stable while i_rd_req.
REQ-011 SHALL have port o_rd_ack, output, 1, one-cycle read-complete pulse.
REQ-012 SHALL have port o_rd_data, output, DATA_W, last read word.
REQ-013 SHALL have port o_busy, output, 1, high in any non-IDLE state.
REQ-014 SHALL have ports o_SRAM_ADDR (output, ADDR_W), io_SRAM_DQ (inout, DATA_W), o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N (outputs, 1 each): SRAM pins.

Function
REQ-015 SHALL implement FSM states IDLE, WR_SETUP, WR_PULSE, RD_ACCESS, RD_DONE.
REQ-016 In IDLE, a request seen at cycle t SHALL latch address (and data for writes) and enter WR_SETUP or RD_ACCESS at t+1.
REQ-017 WR_SETUP -> WR_PULSE -> IDLE unconditionally; RD_ACCESS -> RD_DONE -> IDLE unconditionally; no state lasts more than one cycle.
REQ-018 WR_SETUP: CE_N=0, WE_N=1, OE_N=1, DQ driven with latched data.
REQ-019 WR_PULSE: CE_N=0, WE_N=0, OE_N=1, DQ driven; o_wr_ack=1 (write ack at t+2).
REQ-020 RD_ACCESS: CE_N=0, OE_N=0, WE_N=1, DQ high-Z; io_SRAM_DQ registered into o_rd_data at end of this cycle.
REQ-021 RD_DONE: OE_N=0, CE_N=0; o_rd_ack=1 with o_rd_data valid (read ack at t+2).
REQ-022 o_rd_data SHALL hold its value until the next RD_ACCESS capture.
REQ-023 IDLE: CE_N=1, WE_N=1, OE_N=1, DQ high-Z; o_SRAM_ADDR holds last latched address.
REQ-024 LB_N and UB_N SHALL be 0 at all times (full-word access).
REQ-025 DQ SHALL be driven only in WR_SETUP and WR_PULSE.
REQ-026 Requests arriving in non-IDLE states SHALL wait; no request is dropped while held.
REQ-027 Requester deasserting req before ack SHALL be permitted only in IDLE; otherwise the transaction completes anyway.
REQ-028 Both requests in IDLE: arbitration per REQ-033/034.
REQ-029 Back-to-back requests SHALL yield one transaction every 3 cycles (2 access + 1 IDLE).

Reset
REQ-030 i_rst sampled high SHALL force IDLE at the next edge, including mid-transaction; the interrupted transaction SHALL not be acked.
REQ-031 Reset values: o_wr_ack=0, o_rd_ack=0, o_rd_data=0, o_busy=0, o_SRAM_ADDR=0, WE_N=1, CE_N=1, OE_N=1, DQ high-Z, last-grant=read.

Configuration
REQ-032 Macro SRAM_ARB_RR_EN SHALL select the arbitration policy.
REQ-033 With SRAM_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the port not granted last; last-grant register updates on each grant.
REQ-034 Without SRAM_ARB_RR_EN: fixed priority, write always wins (recording never loses samples); last-grant register absent.

Verification
REQ-035 Write i_wr_addr=0x00010, i_wr_data=0xA5A5 -> WE_N low exactly one cycle at t+2, o_wr_ack=1 at t+2, DQ=0xA5A5 at t+1..t+2.
REQ-036 Read 0x00010 after REQ-035 write (SRAM model) -> o_rd_ack=1 at t+2, o_rd_data=0xA5A5, DQ never driven.
REQ-037 Simultaneous wr/rd in IDLE, both held -> RR build: write then read alternating (last-grant reset=read); fixed build: write first, read granted at t+3.
REQ-038 Continuous write requests, fixed build -> pending read never acked; RR build -> read acked within 6 cycles.
REQ-039 i_rst=1 during WR_PULSE -> next cycle IDLE, WE_N=1, no o_wr_ack, DQ high-Z.
REQ-040 Read request arriving during WR_SETUP -> read enters RD_ACCESS at t+3, acked at t+4.
